// File: rtl/frame_beeper_if.sv
// Sync inputs, enable and PCM outputs of the frame-locked beep generator.
// The video/control side is the master, the beeper is the slave.
interface frame_beeper_if;
    logic               vs;
    logic               hs;
    logic               enable;
    logic signed [15:0] audio_l;
    logic signed [15:0] audio_r;
    logic               beep_active;

    modport master (output vs, hs, enable, input audio_l, audio_r, beep_active);
    modport slave  (input vs, hs, enable, output audio_l, audio_r, beep_active);
endinterface

// File: rtl/frame_beeper.sv
// Frame-synchronised square-wave beep with a line-driven linear decay envelope.
// Every FRAMES_PER_BEEP frame starts a burst of BEEP_FRAMES frames is emitted.
module frame_beeper #(
    parameter bit SYNC_POL        = 1'b0,
    parameter int PHASE_W         = 24,
    parameter int TONE_INC        = 295,
    parameter int FRAMES_PER_BEEP = 60,
    parameter int BEEP_FRAMES     = 6,
    parameter int DECAY_LINES     = 32
) (
    input  logic          pixel_clock,
    input  logic          reset,
    frame_beeper_if.slave bus
);
    localparam int FC_W = (FRAMES_PER_BEEP > 1) ? $clog2(FRAMES_PER_BEEP) : 1;
    localparam int BC_W = $clog2(BEEP_FRAMES + 1);
    localparam int LC_W = (DECAY_LINES > 1) ? $clog2(DECAY_LINES) : 1;

    localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAMES_PER_BEEP - 1);
    localparam logic [BC_W-1:0]    BC_END  = BC_W'(BEEP_FRAMES);
    localparam logic [LC_W-1:0]    LC_LAST = LC_W'(DECAY_LINES - 1);
    localparam logic [PHASE_W-1:0] PH_INC  = PHASE_W'(TONE_INC);

    typedef enum logic {IDLE, BEEP} state_t;

    state_t             state;
    logic               vs_q, hs_q;
    logic [FC_W-1:0]    frame_cnt;
    logic [BC_W-1:0]    beep_cnt;
    logic [LC_W-1:0]    line_cnt;
    logic [7:0]         amp;
    logic [PHASE_W-1:0] phase;
    logic [15:0]        audio;
    logic               active;

    logic               vs_start, hs_start, trigger;
    logic [BC_W-1:0]    beep_cnt_nx;
    logic [15:0]        mag;

    assign vs_start    = (bus.vs == SYNC_POL) && (vs_q != SYNC_POL);
    assign hs_start    = (bus.hs == SYNC_POL) && (hs_q != SYNC_POL);
    assign trigger     = vs_start && (frame_cnt == FC_LAST);
    assign beep_cnt_nx = beep_cnt + BC_W'(1);
    assign mag         = {1'b0, amp, 7'b0};

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state     <= IDLE;
            vs_q      <= ~SYNC_POL;
            hs_q      <= ~SYNC_POL;
            frame_cnt <= '0;
            beep_cnt  <= '0;
            line_cnt  <= '0;
            amp       <= '0;
            phase     <= '0;
            audio     <= '0;
            active    <= 1'b0;
        end else begin
            vs_q <= bus.vs;
            hs_q <= bus.hs;

            // Frame divider keeps running so the beep cadence stays frame-locked
            if (vs_start)
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);

            active <= (state == BEEP);
            if (state == BEEP)
                audio <= phase[PHASE_W-1] ? -mag : mag;
            else
                audio <= '0;

            if (state == IDLE) begin
                if (trigger && bus.enable) begin
                    state    <= BEEP;
                    amp      <= 8'd255;
                    phase    <= '0;
                    beep_cnt <= '0;
                    line_cnt <= '0;
                end
            end else if (!bus.enable) begin
                state <= IDLE;
            end else if (trigger) begin
                amp      <= 8'd255;
                phase    <= '0;
                beep_cnt <= '0;
                line_cnt <= '0;
            end else begin
                phase <= phase + PH_INC;
                if (hs_start) begin
                    if (line_cnt == LC_LAST) begin
                        line_cnt <= '0;
                        amp      <= (amp == 8'd0) ? 8'd0 : amp - 8'd1;
                    end else begin
                        line_cnt <= line_cnt + LC_W'(1);
                    end
                end
                if (vs_start) begin
                    beep_cnt <= beep_cnt_nx;
                    if (beep_cnt_nx == BC_END)
                        state <= IDLE;
                end
            end
        end
    end

    assign bus.audio_l     = audio;
    assign bus.audio_r     = audio;
    assign bus.beep_active = active;
endmodule

// File: tb/tb_frame_beeper.sv
// Bench for frame_beeper: two parameter sets share one stimulus stream and are
// compared each cycle against an event-level model, plus literal spot checks.
module tb_frame_beeper;
    localparam int TONE = 1 << 22;
    localparam int PW   = 24;
    localparam int DL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs  = 1'b1;
    logic hs  = 1'b1;
    logic en  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    frame_beeper_if bif0 ();
    frame_beeper_if bif1 ();
    assign bif0.vs = vs;
    assign bif0.hs = hs;
    assign bif0.enable = en;
    assign bif1.vs = vs;
    assign bif1.hs = hs;
    assign bif1.enable = en;

    frame_beeper #(.SYNC_POL(1'b0), .PHASE_W(PW), .TONE_INC(TONE),
                   .FRAMES_PER_BEEP(3), .BEEP_FRAMES(2), .DECAY_LINES(DL))
        dut0 (.pixel_clock(clk), .reset(rst), .bus(bif0.slave));

    frame_beeper #(.SYNC_POL(1'b0), .PHASE_W(PW), .TONE_INC(TONE),
                   .FRAMES_PER_BEEP(1), .BEEP_FRAMES(3), .DECAY_LINES(DL))
        dut1 (.pixel_clock(clk), .reset(rst), .bus(bif1.slave));

    function automatic int fpb(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int bf(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Model: burst on/off plus counters expressed as plain integers
    int     m_beep[2], m_fc[2], m_bc[2], m_lc[2], m_amp[2];
    longint m_ph[2];
    int     e_audio[2], e_act[2];
    bit     m_vsq = 1'b1, m_hsq = 1'b1;

    function automatic int sample(input longint ph, input int amp);
        return (((ph >> (PW - 1)) & 1) != 0) ? -(amp * 128) : amp * 128;
    endfunction

    task automatic model_step();
        bit vst, hst, trig;
        vst = (vs == 1'b0) && m_vsq;
        hst = (hs == 1'b0) && m_hsq;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_beep[d] = 0; m_fc[d] = 0; m_bc[d] = 0; m_lc[d] = 0;
                m_amp[d] = 0; m_ph[d] = 0; e_audio[d] = 0; e_act[d] = 0;
            end else begin
                trig = vst && (m_fc[d] == fpb(d) - 1);
                if (vst) m_fc[d] = (m_fc[d] + 1) % fpb(d);
                e_act[d]   = m_beep[d];
                e_audio[d] = (m_beep[d] != 0) ? sample(m_ph[d], m_amp[d]) : 0;
                if (m_beep[d] != 0 && !en) begin
                    m_beep[d] = 0;
                end else if (trig && en) begin
                    m_beep[d] = 1; m_amp[d] = 255; m_ph[d] = 0; m_bc[d] = 0; m_lc[d] = 0;
                end else if (m_beep[d] != 0) begin
                    m_ph[d] = (m_ph[d] + TONE) % (longint'(1) << PW);
                    if (hst) begin
                        m_lc[d]++;
                        if (m_lc[d] == DL) begin
                            m_lc[d] = 0;
                            if (m_amp[d] > 0) m_amp[d]--;
                        end
                    end
                    if (vst) begin
                        m_bc[d]++;
                        if (m_bc[d] == bf(d)) m_beep[d] = 0;
                    end
                end
            end
        end
        if (rst) begin
            m_vsq = 1'b1; m_hsq = 1'b1;
        end else begin
            m_vsq = vs; m_hsq = hs;
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp_v);
        n_cmp++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp_v, $time);
        end
    endtask

    function automatic int mag_of(input logic [15:0] a);
        int v;
        v = $signed(a);
        return (v < 0) ? -v : v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("d0_audio_l", $signed(bif0.audio_l), e_audio[0]);
            chk("d0_audio_r", $signed(bif0.audio_r), e_audio[0]);
            chk("d0_active", int'(bif0.beep_active), e_act[0]);
            chk("d1_audio_l", $signed(bif1.audio_l), e_audio[1]);
            chk("d1_audio_r", $signed(bif1.audio_r), e_audio[1]);
            chk("d1_active", int'(bif1.beep_active), e_act[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic vs_pulse();
        vs = 1'b0; cyc();
        vs = 1'b1; cyc();
    endtask

    task automatic hs_pulse();
        hs = 1'b0; cyc();
        hs = 1'b1; cyc();
    endtask

    initial begin
        cyc();
        chk_on = 1'b1;
        cyc();
        chk("reset_audio", $signed(bif0.audio_l), 0);
        chk("reset_active", int'(bif0.beep_active), 0);

        // Third frame start triggers dut0; first sample one edge later
        rst = 1'b0; en = 1'b1;
        cyc(); cyc();
        vs_pulse(); cyc(); vs_pulse(); cyc(); vs_pulse();
        chk("first_active", int'(bif0.beep_active), 1);
        chk("first_sample", $signed(bif0.audio_l), 32640);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk($sformatf("square_%0d", k), $signed(bif0.audio_l),
                (((k / 2) % 2) != 0) ? -32640 : 32640);
        end

        repeat (8) hs_pulse();
        chk("decay_253", mag_of(bif0.audio_l), 32384);
        repeat (1100) hs_pulse();
        chk("sat_audio", $signed(bif0.audio_l), 0);
        chk("sat_active", int'(bif0.beep_active), 1);

        // Two more frame starts end dut0's burst; dut1 retriggers each time
        vs_pulse(); vs_pulse();
        chk("burst_end", int'(bif0.beep_active), 0);
        chk("retrig_active", int'(bif1.beep_active), 1);
        chk("retrig_amp", $signed(bif1.audio_l), 32640);

        vs_pulse();
        chk("trig2_active", int'(bif0.beep_active), 1);
        cyc(); cyc(); cyc();
        en = 1'b0; cyc(); cyc();
        chk("dis_audio", $signed(bif0.audio_l), 0);
        chk("dis_active", int'(bif0.beep_active), 0);
        vs_pulse(); vs_pulse();
        chk("dis_no_beep", int'(bif0.beep_active), 0);
        en = 1'b1; cyc();
        vs_pulse();
        chk("reen_active", int'(bif0.beep_active), 1);
        chk("reen_sample", $signed(bif0.audio_l), 32640);

        cyc(); cyc();
        rst = 1'b1; cyc();
        chk("rst_mid_audio", $signed(bif0.audio_l), 0);
        chk("rst_mid_active", int'(bif0.beep_active), 0);
        rst = 1'b0;

        vs_pulse(); vs_pulse(); vs_pulse();
        repeat (3) hs_pulse();
        vs = 1'b0; hs = 1'b0; cyc();
        vs = 1'b1; hs = 1'b1; cyc();
        chk("coinc_amp", mag_of(bif0.audio_l), 32512);
        vs_pulse();
        chk("coinc_bcnt", int'(bif0.beep_active), 0);

        repeat (4000) begin
            vs  = ($urandom_range(0, 15) != 0);
            hs  = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0; vs = 1'b1; hs = 1'b1;
        cyc(); cyc();
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
